// File: rtl/pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// pc_fetch_unit
//
// Program counter and instruction-fetch stage for the MIPS-16 pipeline. Holds
// the PC, picks the next PC (reset vector, jump, hold or increment), reads a
// synchronous on-chip program memory and presents one registered instruction
// per cycle to decode, together with a valid flag and the fetch address.
//
// A jump requested while the whole stage is frozen (stall_pm_i) is remembered
// in a pending register and applied on the first unfrozen cycle, unless a live
// jump arrives in that same cycle, in which case the live target wins.
//
// Ports:
//   clk_i              clock, all state changes on the rising edge
//   reset_i            synchronous active-high reset
//   jump_loc_i         jump/branch target address
//   pc_mux_sel_i       1 = take jump_loc_i as the next PC
//   stall_i            hazard stall: hold PC and emit a bubble
//   stall_pm_i         freeze PC and all outputs
//   pm_we_i            program memory write enable
//   pm_waddr_i         program memory write address
//   pm_wdata_i         program memory write data
//   ins_o              fetched instruction (registered)
//   ins_valid_o        ins_o is a real, on-path instruction
//   current_address_o  address ins_o was fetched from
//   addr_err_o         ins_o came from an address >= DEPTH
// -----------------------------------------------------------------------------
module pc_fetch_unit #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned INS_W = 32,
  parameter int unsigned DEPTH = 256,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter logic [INS_W-1:0] NOP_INS = '0
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [ADDR_W-1:0] jump_loc_i,
  input  logic              pc_mux_sel_i,
  input  logic              stall_i,
  input  logic              stall_pm_i,
  input  logic              pm_we_i,
  input  logic [ADDR_W-1:0] pm_waddr_i,
  input  logic [INS_W-1:0]  pm_wdata_i,
  output logic [INS_W-1:0]  ins_o,
  output logic              ins_valid_o,
  output logic [ADDR_W-1:0] current_address_o,
  output logic              addr_err_o
);

  // Memory index width; DEPTH <= 2^ADDR_W keeps it within the PC width.
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // DEPTH held one bit wider than an address so DEPTH = 2^ADDR_W still fits.
  localparam logic [ADDR_W:0] DEPTH_L = DEPTH[ADDR_W:0];

  localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [INS_W-1:0]  mem [DEPTH];

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [INS_W-1:0]  ins_q, ins_d;
  logic              ins_valid_q, ins_valid_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic              addr_err_q, addr_err_d;
  logic              pend_valid_q, pend_valid_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;

  logic              pc_in_range;
  logic              waddr_in_range;
  logic [INS_W-1:0]  rd_data;

  assign pc_in_range    = ({1'b0, pc_q} < DEPTH_L);
  assign waddr_in_range = ({1'b0, pm_waddr_i} < DEPTH_L);

  // Only meaningful when pc_in_range; out-of-range fetches substitute NOP_INS.
  assign rd_data = mem[pc_q[IDX_W-1:0]];

  // Preload/write port. Not reset and not gated by either stall, so the
  // program can be loaded while the pipeline is held in reset. Because the
  // fetch samples rd_data in the same edge, a same-address read sees the
  // old word.
  always_ff @(posedge clk_i) begin
    if (pm_we_i && waddr_in_range) begin
      mem[pm_waddr_i[IDX_W-1:0]] <= pm_wdata_i;
    end
  end

  // Next-state selection: freeze, then jump (live or pending), then hazard
  // stall, then sequential fetch. A jump squashes the wrong-path fetch by
  // emitting a bubble, so taken jumps cost one cycle.
  always_comb begin
    pc_d         = pc_q;
    ins_d        = ins_q;
    ins_valid_d  = ins_valid_q;
    cur_addr_d   = cur_addr_q;
    addr_err_d   = addr_err_q;
    pend_valid_d = pend_valid_q;
    pend_addr_d  = pend_addr_q;

    if (stall_pm_i) begin
      if (pc_mux_sel_i) begin
        pend_valid_d = 1'b1;
        pend_addr_d  = jump_loc_i;
      end
    end else if (pc_mux_sel_i || pend_valid_q) begin
      pc_d         = pc_mux_sel_i ? jump_loc_i : pend_addr_q;
      ins_d        = NOP_INS;
      ins_valid_d  = 1'b0;
      cur_addr_d   = pc_q;
      addr_err_d   = 1'b0;
      pend_valid_d = 1'b0;
    end else if (stall_i) begin
      ins_d       = NOP_INS;
      ins_valid_d = 1'b0;
      cur_addr_d  = pc_q;
      addr_err_d  = 1'b0;
    end else begin
      pc_d        = pc_q + PC_ONE;
      ins_d       = pc_in_range ? rd_data : NOP_INS;
      ins_valid_d = 1'b1;
      cur_addr_d  = pc_q;
      addr_err_d  = ~pc_in_range;
    end
  end

  // Pipeline state registers with synchronous reset; reset also drops any
  // pending jump captured during a freeze.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pc_q         <= RESET_VEC;
      ins_q        <= NOP_INS;
      ins_valid_q  <= 1'b0;
      cur_addr_q   <= '0;
      addr_err_q   <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_addr_q  <= '0;
    end else begin
      pc_q         <= pc_d;
      ins_q        <= ins_d;
      ins_valid_q  <= ins_valid_d;
      cur_addr_q   <= cur_addr_d;
      addr_err_q   <= addr_err_d;
      pend_valid_q <= pend_valid_d;
      pend_addr_q  <= pend_addr_d;
    end
  end

  assign ins_o             = ins_q;
  assign ins_valid_o       = ins_valid_q;
  assign current_address_o = cur_addr_q;
  assign addr_err_o        = addr_err_q;

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
Parametrised program-counter and instruction-fetch stage for the MIPS-16 pipeline, and the successor to the fixed-width program memory. It holds the PC, selects the next PC (reset vector, jump, hold or increment) and reads a synchronous on-chip program memory. It presents one instruction per cycle to decode with a valid flag. It adds a preload write port, an out-of-range flag, bubble insertion on stall or jump, and a pending-jump capture while the fetch stage is frozen.

Parameters:
ADDR_W, 16, PC and address width (PC counts words).
INS_W, 32, instruction width.
DEPTH, 256, number of program memory words; must be ≤ 2^ADDR_W.
RESET_VEC, 0, PC value loaded on reset.
NOP_INS, 0, instruction emitted for bubbles and out-of-range fetches.

Ports:
clk  in  1  clock, all state updates on the rising edge.
reset  in  1  synchronous, active-high reset.
jump_loc  in  ADDR_W  jump/branch target.
pc_mux_sel  in  1  1 = take jump_loc as next PC.
stall  in  1  hazard stall: hold PC, emit a bubble.
stall_pm  in  1  freeze the whole fetch stage (PC and outputs).
pm_we  in  1  program memory write enable.
pm_waddr  in  ADDR_W  write address.
pm_wdata  in  INS_W  write data.
ins  out  INS_W  fetched instruction (registered).
ins_valid  out  1  ins is a real, on-path instruction.
current_address  out  ADDR_W  address that ins was fetched from.
addr_err  out  1  ins came from an address ≥ DEPTH.

Behaviour:
- Reset values (at the edge while reset=1): pc=RESET_VEC, ins=NOP_INS, ins_valid=0, current_address=0, addr_err=0, pending jump cleared.
- Memory contents are not reset.
- Next-PC priority, evaluated each non-reset cycle:
  1. stall_pm: pc holds; ins, ins_valid, current_address and addr_err hold.
  2. pc_mux_sel (or a pending jump when stall_pm=0): pc←target; outputs ins←NOP_INS, ins_valid←0, current_address←pc, addr_err←0. This squashes the wrong-path fetch, giving a 1-cycle jump penalty.
  3. stall: pc holds; ins←NOP_INS, ins_valid←0, current_address←pc, addr_err←0.
  4. Otherwise: pc←pc+1, wrapping modulo 2^ADDR_W (0xFFFF→0x0000 at ADDR_W=16). Outputs: ins←mem[pc] (NOP_INS if pc≥DEPTH), ins_valid←1, current_address←pc, addr_err←(pc≥DEPTH).
- Fetch latency: one cycle from PC value to ins. The first valid ins appears after the first rising edge with reset=0, at address RESET_VEC.
- Pending jump:
  - If pc_mux_sel=1 while stall_pm=1, jump_loc is captured into a pending register; a later capture overwrites it.
  - In the first cycle with stall_pm=0, the pending jump is applied as case 2 and then cleared.
  - If pc_mux_sel=1 in that same cycle, the live jump_loc wins and the pending jump is discarded.
  - reset discards any pending jump.
- Write port:
  - When pm_we=1 and pm_waddr<DEPTH, mem[pm_waddr]←pm_wdata at the edge.
  - Writes with pm_waddr≥DEPTH are ignored.
  - Writes are accepted during reset and during either stall.
  - Same-cycle read and write of the same address returns the old data (read-first).
- stall and stall_pm asserted together behave as stall_pm.
- reset asserted mid-operation overrides everything in that cycle.

Test Plan:
- Setup for all scenarios: DEPTH=256, ADDR_W=16; preload mem[k]=0xA000_0000+k during reset.
- Reset → run: release reset. Expect ins=0xA0000000, 0xA0000001, 0xA0000002 on consecutive cycles, with current_address 0,1,2 and ins_valid=1.
- Jump: pc_mux_sel=1, jump_loc=0x0008 for one cycle while pc=3. Expect next output ins_valid=0, ins=0. Then 0xA0000008 at addr 8, then 0xA0000009 at addr 9.
- stall for 2 cycles at pc=5: two outputs with ins_valid=0. Then 0xA0000005 at addr 5; no address skipped or repeated.
- stall_pm for 3 cycles with a pc_mux_sel pulse, jump_loc=0x0040, in the middle cycle: outputs frozen at their prior values for all 3 cycles. After release, one bubble, then 0xA0000040 at addr 0x40.
- Range and wrap:
  - Jump to 0x0100: output ins=0, ins_valid=1, addr_err=1.
  - Jump to 0xFFFF: addr 0xFFFF (addr_err=1), then addr 0x0000 with ins=0xA0000000 and addr_err=0.
  - A write to 0x0100 leaves memory unchanged.
- Reset mid-stream: assert reset during stall_pm with a pending jump to 0x0040. After release, fetch restarts at 0x0000 and the pending jump is never taken.
